gpu_fill_engine: RTL
====================

Name: gpu_fill_engine

Overview:
Parametrised, buffered successor to the single-op render path. It accepts draw commands into an internal FIFO of configurable depth, rasterises filled rectangles and single pixels into a double-buffered framebuffer, and issues pixel writes on the AHB master side with HREADY back-pressure. It sits between the APB command decoder and the AHB bus, replacing the separate render, memory-manager and controller trio with one queued engine.

Parameters:
FB_WIDTH, 320, framebuffer width in pixels
FB_HEIGHT, 240, framebuffer height in pixels
X_W, 9, x coordinate width (must satisfy FB_WIDTH <= 2^X_W)
Y_W, 8, y coordinate width (must satisfy FB_HEIGHT <= 2^Y_W)
FIFO_DEPTH, 4, command queue entries (power of 2, >= 2)
BUF0_BASE, 32'h0000_0000, byte base address of buffer 0
BUF1_BASE, 32'h0005_0000, byte base address of buffer 1

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept; equals !full
cmd_op  in  2  0 = NOP, 1 = PIXEL, 2 = FILL, 3 = FLIP
cmd_x0, cmd_x1  in  X_W  corner x coordinates
cmd_y0, cmd_y1  in  Y_W  corner y coordinates
cmd_color  in  32  pixel data
HADDR  out  32  write address
HWDATA  out  32  write data
HWRITE  out  1  write request
HREADY  in  1  slave accepts the current write
busy  out  1  engine not IDLE or FIFO not empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  queued entries
front_buf  out  1  buffer currently displayed
done  out  1  one-cycle pulse when all work completes
pix_count  out  32  completed pixel writes (see Optional Feature)

Behaviour:
- Reset: clk, n_rst as above; n_rst is asynchronous and active-low.
- Reset values: all outputs 0, except cmd_ready = 1. FIFO is emptied, front_buf = 0, draw buffer = 1, FSM = IDLE.
- Push: when cmd_valid && cmd_ready, the command is stored. A push while full is refused, even if a pop happens in the same cycle.
- Simultaneous push and pop while not full: fifo_count is unchanged.
- FSM states: IDLE, LOAD, DRAW, FLIP.
- IDLE: if FIFO is non-empty, pop the head and go to LOAD.
- LOAD (1 cycle): normalise corners so that xs = min(x0, x1), xe = max(x0, x1), and likewise for y.
  - Clip xe to FB_WIDTH-1 and ye to FB_HEIGHT-1.
  - PIXEL uses (x0, y0) only.
  - Go to DRAW if op is PIXEL or FILL and xs < FB_WIDTH and ys < FB_HEIGHT.
  - Go to FLIP if op is FLIP.
  - Otherwise go to IDLE with no writes (NOP or fully off-screen).
- DRAW: HWRITE = 1.
  - HADDR = base(draw buffer) + ((y*FB_WIDTH + x) << 2); HWDATA = latched color.
  - While HREADY = 0, HADDR, HWDATA and HWRITE hold stable.
  - On HREADY = 1 the pixel completes and the engine advances in raster order: x++, and at x == xe it sets x = xs, y++.
  - After the pixel (xe, ye) completes: HWRITE = 0 in the next cycle and the FSM goes to IDLE.
- FLIP (1 cycle): toggle front_buf and the draw buffer, then go to IDLE. A FLIP takes effect only after all earlier commands have completed.
- Latency: command accepted at cycle N gives LOAD at N+1 and first HWRITE at N+2 when the engine is idle. Throughput is 1 pixel per cycle with HREADY held high.
- done: asserted for 1 cycle when the FSM enters IDLE from LOAD, DRAW or FLIP and the FIFO is empty with no push in that cycle.
- Arithmetic: address is computed at 32-bit width. The multiply uses constant FB_WIDTH.
- Reset mid-DRAW: HWRITE drops immediately (asynchronous), the queue is discarded and buffers return to their reset assignment.

Optional Feature:
PERF_COUNT_EN
- Defined: pix_count increments on every cycle with HWRITE && HREADY, and saturates at 32'hFFFF_FFFF. It is cleared only by reset.
- Undefined: pix_count is tied to 0 and no counter logic is built.

Test Plan:
1. PIXEL at (3,2), color 32'hAABBCCDD, HREADY = 1 -> single write: HADDR = 32'h0005_0000 + (2*320+3)*4 = 32'h0005_0A0C, HWDATA = AABBCCDD; done pulses 1 cycle later.
2. FILL with x0 = 5, x1 = 4, y0 = 1, y1 = 0 -> 4 writes, in order (4,0), (5,0), (4,1), (5,1), on consecutive cycles.
3. Same FILL with HREADY low for 3 cycles on the second pixel -> HADDR/HWDATA held stable for 3 cycles; 4 writes total; pix_count = 4 with PERF_COUNT_EN.
4. Push 5 commands back-to-back while the engine is stalled (FIFO_DEPTH = 4) -> cmd_ready = 0 after 4 queued (one popped into LOAD gives fifo_count = 3 then refill to 4); the fifth push is accepted only after a pop; no command is lost.
5. FILL x0 = 318..330, y0 = y1 = 239 -> 2 writes, at x = 318 and 319. FILL with xs = 400 -> no writes, done pulses.
6. FLIP queued after a PIXEL -> front_buf toggles to 1 only after the PIXEL write completes. The next PIXEL (0,0) writes HADDR = 32'h0000_0000. n_rst pulsed mid-FILL -> HWRITE = 0 immediately, fifo_count = 0, front_buf = 0.

Source files
------------

// File: rtl/gpu_fill_engine_if.sv
// Bus bundle for gpu_fill_engine: command push port, AHB-style write master and status.
// master = engine side, slave = command source / bus side.
interface gpu_fill_engine_if #(
  parameter int X_W   = 9,
  parameter int Y_W   = 8,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [X_W-1:0]   cmd_x0;
  logic [X_W-1:0]   cmd_x1;
  logic [Y_W-1:0]   cmd_y0;
  logic [Y_W-1:0]   cmd_y1;
  logic [31:0]      cmd_color;
  logic [31:0]      HADDR;
  logic [31:0]      HWDATA;
  logic             HWRITE;
  logic             HREADY;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;
  logic             front_buf;
  logic             done;
  logic [31:0]      pix_count;

  modport master (
    input  cmd_valid, cmd_op, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, HREADY,
    output cmd_ready, HADDR, HWDATA, HWRITE, busy, fifo_count, front_buf, done, pix_count
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, HREADY,
    input  cmd_ready, HADDR, HWDATA, HWRITE, busy, fifo_count, front_buf, done, pix_count
  );
endinterface

// File: rtl/gpu_fill_engine.sv
// Queued rectangle/pixel fill engine writing a double-buffered framebuffer over AHB.
// Optional macro PERF_COUNT_EN builds the saturating completed-pixel counter on pix_count.
//
// state | meaning
// IDLE  | waiting; pops the queue head (or takes the input directly when empty)
// LOAD  | normalise and clip the latched corners, pick next state
// DRAW  | one pixel write per HREADY, raster order
// FLIP  | swap front/draw buffers
module gpu_fill_engine #(
  parameter int          FB_WIDTH   = 320,
  parameter int          FB_HEIGHT  = 240,
  parameter int          X_W        = 9,
  parameter int          Y_W        = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BUF0_BASE  = 32'h0000_0000,
  parameter logic [31:0] BUF1_BASE  = 32'h0005_0000
) (
  input  logic         clk,
  input  logic         n_rst,
  gpu_fill_engine_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] OP_PIXEL = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;
  localparam logic [1:0] OP_FLIP  = 2'd3;
  localparam logic [X_W-1:0] X_MAX = X_W'(FB_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(FB_HEIGHT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAW, ST_FLIP} state_t;

  typedef struct packed {
    logic [1:0]     op;
    logic [X_W-1:0] x0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y0;
    logic [Y_W-1:0] y1;
    logic [31:0]    color;
  } cmd_t;

  state_t         state_q, state_d;
  cmd_t           mem_q [FIFO_DEPTH];
  cmd_t           cmd_in, cmd_head, cmd_q, cmd_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [X_W-1:0] x_q, x_d, xs_q, xs_d, xe_q, xe_d;
  logic [Y_W-1:0] y_q, y_d, ye_q, ye_d;
  logic           front_q, front_d;
  logic           done_q, done_d;

  logic           full, empty, push, take, bypass, store, pop_fifo;
  logic [X_W-1:0] xs_c, xe_r, xe_c;
  logic [Y_W-1:0] ys_c, ye_r, ye_c;
  logic           on_screen, drawing;
  logic [31:0]    pix_off, draw_base;

  assign cmd_in = {bus.cmd_op, bus.cmd_x0, bus.cmd_x1, bus.cmd_y0, bus.cmd_y1, bus.cmd_color};

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = bus.cmd_valid && !full;
  assign take     = (state_q == ST_IDLE) && (!empty || push);
  // An idle engine with an empty queue takes the input straight into LOAD.
  assign bypass   = take && empty;
  assign store    = push && !bypass;
  assign pop_fifo = take && !empty;
  assign cmd_head = empty ? cmd_in : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({store, pop_fifo})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_comb begin
    if (cmd_q.op == OP_PIXEL) begin
      xs_c = cmd_q.x0;
      xe_r = cmd_q.x0;
      ys_c = cmd_q.y0;
      ye_r = cmd_q.y0;
    end else begin
      xs_c = (cmd_q.x0 < cmd_q.x1) ? cmd_q.x0 : cmd_q.x1;
      xe_r = (cmd_q.x0 < cmd_q.x1) ? cmd_q.x1 : cmd_q.x0;
      ys_c = (cmd_q.y0 < cmd_q.y1) ? cmd_q.y0 : cmd_q.y1;
      ye_r = (cmd_q.y0 < cmd_q.y1) ? cmd_q.y1 : cmd_q.y0;
    end
    xe_c      = (xe_r > X_MAX) ? X_MAX : xe_r;
    ye_c      = (ye_r > Y_MAX) ? Y_MAX : ye_r;
    on_screen = (32'(xs_c) < 32'(FB_WIDTH)) && (32'(ys_c) < 32'(FB_HEIGHT));
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    x_d     = x_q;
    y_d     = y_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    front_d = front_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          cmd_d   = cmd_head;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        xs_d = xs_c;
        xe_d = xe_c;
        ye_d = ye_c;
        x_d  = xs_c;
        y_d  = ys_c;
        if (cmd_q.op == OP_FLIP)
          state_d = ST_FLIP;
        else if ((cmd_q.op == OP_PIXEL || cmd_q.op == OP_FILL) && on_screen)
          state_d = ST_DRAW;
        else
          state_d = ST_IDLE;
      end
      ST_DRAW: begin
        if (bus.HREADY) begin
          if (x_q == xe_q) begin
            x_d = xs_q;
            if (y_q == ye_q) state_d = ST_IDLE;
            else             y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      ST_FLIP: begin
        front_d = !front_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE) && empty && !push;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      xs_q     <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
      front_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      wr_ptr_q <= store    ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q <= pop_fifo ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_q  <= count_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xs_q     <= xs_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
      front_q  <= front_d;
      done_q   <= done_d;
    end
  end

  // Draw buffer is always the one not on display.
  assign drawing   = (state_q == ST_DRAW);
  assign draw_base = front_q ? BUF0_BASE : BUF1_BASE;
  assign pix_off   = (32'(y_q) * 32'(FB_WIDTH) + 32'(x_q)) << 2;

  assign bus.HWRITE     = drawing;
  assign bus.HADDR      = drawing ? (draw_base + pix_off) : '0;
  assign bus.HWDATA     = drawing ? cmd_q.color : '0;
  assign bus.cmd_ready  = !full;
  assign bus.busy       = (state_q != ST_IDLE) || !empty;
  assign bus.fifo_count = count_q;
  assign bus.front_buf  = front_q;
  assign bus.done       = done_q;

`ifdef PERF_COUNT_EN
  logic [31:0] pix_q, pix_d;

  always_comb begin
    pix_d = pix_q;
    if (drawing && bus.HREADY && (pix_q != 32'hFFFF_FFFF)) pix_d = pix_q + 32'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) pix_q <= '0;
    else        pix_q <= pix_d;
  end

  assign bus.pix_count = pix_q;
`else
  assign bus.pix_count = '0;
`endif
endmodule
